// File: rtl/execute_memory_stage_reg_pkg.sv
// Shared types for the EX->MEM pipeline register: field encodings and the
// per-edge update select that the control and data paths both follow.
package execute_memory_stage_reg_pkg;

    localparam int DEF_RSRC_W   = 2;
    localparam int DEF_DWIDTH_W = 3;

    // Writeback mux select
    typedef enum logic [DEF_RSRC_W-1:0] {
        RS_ALU = 2'd0,
        RS_MEM = 2'd1,
        RS_PC4 = 2'd2
    } result_src_e;

    // Load/store access size; bit 2 marks zero-extension on loads
    typedef enum logic [DEF_DWIDTH_W-1:0] {
        DW_B  = 3'd0,
        DW_H  = 3'd1,
        DW_W  = 3'd2,
        DW_BU = 3'd4,
        DW_HU = 3'd5
    } data_width_e;

    // What the M-stage register does on the coming edge (reset handled separately)
    typedef enum logic [1:0] {
        SEL_LOAD  = 2'd0,
        SEL_HOLD  = 2'd1,
        SEL_FLUSH = 2'd2
    } stage_sel_e;

endpackage

// File: rtl/execute_memory_stage_reg_if.sv
// Bundle of hazard controls, E-stage inputs and M-stage outputs of the
// EX->MEM register. master = surrounding pipeline, slave = the register.
interface execute_memory_stage_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6,
    parameter int RSRC_W     = 2,
    parameter int DWIDTH_W   = 3,
    parameter int CNT_W      = 16
);
    logic                  StallM;
    logic                  FlushM;
    logic                  ValidE;
    logic                  RegWriteE;
    logic [RSRC_W-1:0]     ResultSrcE;
    logic                  MemWriteE;
    logic [DWIDTH_W-1:0]   DataWidthE;
    logic [DATA_W-1:0]     ALUOutE;
    logic [DATA_W-1:0]     WriteDataE;
    logic [REG_ADDR_W-1:0] RDE;
    logic [DATA_W-1:0]     PCPlus4E;

    logic                  ValidM;
    logic                  RegWriteM;
    logic [RSRC_W-1:0]     ResultSrcM;
    logic                  MemWriteM;
    logic [DWIDTH_W-1:0]   DataWidthM;
    logic [DATA_W-1:0]     ALUOutM;
    logic [DATA_W-1:0]     WriteDataM;
    logic [REG_ADDR_W-1:0] RDM;
    logic [DATA_W-1:0]     PCPlus4M;
    logic [CNT_W-1:0]      StallCnt;
    logic [CNT_W-1:0]      BubbleCnt;

    modport master (
        output StallM, FlushM, ValidE, RegWriteE, ResultSrcE, MemWriteE,
               DataWidthE, ALUOutE, WriteDataE, RDE, PCPlus4E,
        input  ValidM, RegWriteM, ResultSrcM, MemWriteM, DataWidthM,
               ALUOutM, WriteDataM, RDM, PCPlus4M, StallCnt, BubbleCnt
    );

    modport slave (
        input  StallM, FlushM, ValidE, RegWriteE, ResultSrcE, MemWriteE,
               DataWidthE, ALUOutE, WriteDataE, RDE, PCPlus4E,
        output ValidM, RegWriteM, ResultSrcM, MemWriteM, DataWidthM,
               ALUOutM, WriteDataM, RDM, PCPlus4M, StallCnt, BubbleCnt
    );

endinterface

// File: rtl/execute_memory_stage_reg_sat_counter.sv
// Saturating up-counter for performance debug; sticks at all-ones and
// is cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next value: step by one unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Counter register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/execute_memory_stage_reg.sv
// EX->MEM pipeline register with hold (stall), bubble insertion (flush),
// valid tracking and saturating stall/bubble counters. All outputs come
// straight from flops.
module execute_memory_stage_reg
    import execute_memory_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6,
    parameter int RSRC_W     = DEF_RSRC_W,
    parameter int DWIDTH_W   = DEF_DWIDTH_W,
    parameter int CNT_W      = 16
) (
    input logic                        clk,
    input logic                        rst,
    execute_memory_stage_reg_if.slave  bus
);

    stage_sel_e            sel_d;

    logic                  valid_q;
    logic                  reg_write_q;
    logic                  mem_write_q;
    logic [RSRC_W-1:0]     result_src_q;
    logic [DWIDTH_W-1:0]   data_width_q;
    logic [DATA_W-1:0]     alu_out_q;
    logic [DATA_W-1:0]     write_data_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     pc_plus4_q;

    logic                  stall_inc;
    logic                  bubble_inc;

    // One select shared by both paths: flush beats stall beats load
    always_comb begin
        sel_d = SEL_LOAD;
        if (bus.FlushM)      sel_d = SEL_FLUSH;
        else if (bus.StallM) sel_d = SEL_HOLD;
    end

    // Control path: a bubble never carries a write enable
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (sel_d)
                SEL_FLUSH: begin
                    valid_q     <= 1'b0;
                    reg_write_q <= 1'b0;
                    mem_write_q <= 1'b0;
                end
                SEL_HOLD: ;
                default: begin
                    valid_q     <= bus.ValidE;
                    reg_write_q <= bus.RegWriteE & bus.ValidE;
                    mem_write_q <= bus.MemWriteE & bus.ValidE;
                end
            endcase
        end
    end

    // Data path: fields follow E on load and flush, hold on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            result_src_q <= '0;
            data_width_q <= '0;
            alu_out_q    <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
        end else if (sel_d != SEL_HOLD) begin
            result_src_q <= bus.ResultSrcE;
            data_width_q <= bus.DataWidthE;
            alu_out_q    <= bus.ALUOutE;
            write_data_q <= bus.WriteDataE;
            rd_q         <= bus.RDE;
            pc_plus4_q   <= bus.PCPlus4E;
        end
    end

    // Stalls count only while a real instruction is held; bubbles count
    // flushes and loads of an invalid E-stage slot
    assign stall_inc  = (sel_d == SEL_HOLD) && valid_q;
    assign bubble_inc = (sel_d == SEL_FLUSH) || ((sel_d == SEL_LOAD) && !bus.ValidE);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc),
        .count_o (bus.StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (bubble_inc),
        .count_o (bus.BubbleCnt)
    );

    assign bus.ValidM     = valid_q;
    assign bus.RegWriteM  = reg_write_q;
    assign bus.MemWriteM  = mem_write_q;
    assign bus.ResultSrcM = result_src_q;
    assign bus.DataWidthM = data_width_q;
    assign bus.ALUOutM    = alu_out_q;
    assign bus.WriteDataM = write_data_q;
    assign bus.RDM        = rd_q;
    assign bus.PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_memory_stage_reg.sv
// Directed + random bench for the EX->MEM register, compared every cycle
// against a transaction-level model of the M-stage contents.
module tb_execute_memory_stage_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 6;
    localparam int RSRC_W     = 2;
    localparam int DWIDTH_W   = 3;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    execute_memory_stage_reg_if #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .RSRC_W(RSRC_W),
        .DWIDTH_W(DWIDTH_W), .CNT_W(CNT_W)
    ) ifc ();

    execute_memory_stage_reg #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .RSRC_W(RSRC_W),
        .DWIDTH_W(DWIDTH_W), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Expected M-stage contents
    typedef struct {
        bit        valid, rw, mw;
        bit [31:0] rsrc, dw, alu, wd, rd, pc4;
        int        stall_cnt, bubble_cnt;
    } mstate_t;

    mstate_t m;

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Apply one clock edge to the model from the inputs currently driven
    task automatic model_edge();
        if (rst) begin
            m = '{default: 0};
        end else if (ifc.FlushM || !ifc.StallM) begin
            bit flush = ifc.FlushM;
            if (flush || !ifc.ValidE) m.bubble_cnt = sat_inc(m.bubble_cnt);
            m.valid = flush ? 1'b0 : ifc.ValidE;
            m.rw    = flush ? 1'b0 : (ifc.ValidE && ifc.RegWriteE);
            m.mw    = flush ? 1'b0 : (ifc.ValidE && ifc.MemWriteE);
            m.rsrc  = 32'(ifc.ResultSrcE);
            m.dw    = 32'(ifc.DataWidthE);
            m.alu   = ifc.ALUOutE;
            m.wd    = ifc.WriteDataE;
            m.rd    = 32'(ifc.RDE);
            m.pc4   = ifc.PCPlus4E;
        end else if (m.valid) begin
            m.stall_cnt = sat_inc(m.stall_cnt);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ValidM"},     32'(ifc.ValidM),     32'(m.valid));
        chk({tag, ".RegWriteM"},  32'(ifc.RegWriteM),  32'(m.rw));
        chk({tag, ".MemWriteM"},  32'(ifc.MemWriteM),  32'(m.mw));
        chk({tag, ".ResultSrcM"}, 32'(ifc.ResultSrcM), m.rsrc);
        chk({tag, ".DataWidthM"}, 32'(ifc.DataWidthM), m.dw);
        chk({tag, ".ALUOutM"},    ifc.ALUOutM,         m.alu);
        chk({tag, ".WriteDataM"}, ifc.WriteDataM,      m.wd);
        chk({tag, ".RDM"},        32'(ifc.RDM),        m.rd);
        chk({tag, ".PCPlus4M"},   ifc.PCPlus4M,        m.pc4);
        chk({tag, ".StallCnt"},   32'(ifc.StallCnt),   32'(m.stall_cnt));
        chk({tag, ".BubbleCnt"},  32'(ifc.BubbleCnt),  32'(m.bubble_cnt));
    endtask

    // One clock: model follows the edge, DUT is sampled 1 time unit later
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_e();
        ifc.RegWriteE  = 1'($urandom);
        ifc.MemWriteE  = 1'($urandom);
        ifc.ResultSrcE = RSRC_W'($urandom_range(0, 2));
        ifc.DataWidthE = DWIDTH_W'($urandom);
        ifc.ALUOutE    = $urandom;
        ifc.WriteDataE = $urandom;
        ifc.RDE        = REG_ADDR_W'($urandom);
        ifc.PCPlus4E   = $urandom;
    endtask

    initial begin
        m = '{default: 0};
        rst = 1'b1;
        ifc.StallM = 1'b0; ifc.FlushM = 1'b0; ifc.ValidE = 1'b1;
        rand_e();

        // 1: reset with live-looking E inputs
        ifc.ALUOutE = 32'hDEAD_BEEF; ifc.RegWriteE = 1'b1;
        step("t1_rst0");
        step("t1_rst1");
        chk("t1_alu_zero", ifc.ALUOutM, 32'h0);
        rst = 1'b0;
        #1 check_all("t1_post");

        // 2: plain load
        ifc.ALUOutE = 32'h0000_1234; ifc.RDE = 6'd5; ifc.RegWriteE = 1'b1; ifc.ValidE = 1'b1;
        step("t2_load");
        chk("t2_alu", ifc.ALUOutM, 32'h1234);
        chk("t2_rd", 32'(ifc.RDM), 32'd5);
        chk("t2_valid_rw", {30'd0, ifc.ValidM, ifc.RegWriteM}, 32'h3);

        // 3: stall 3 cycles while E changes
        ifc.StallM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_e();
            step("t3_stall");
        end
        chk("t3_alu_held", ifc.ALUOutM, 32'h1234);
        chk("t3_stallcnt", 32'(ifc.StallCnt), 32'd3);

        // 4: flush during stall
        ifc.FlushM = 1'b1; ifc.MemWriteE = 1'b1; ifc.RegWriteE = 1'b1;
        step("t4_flush");
        chk("t4_ctl", {29'd0, ifc.ValidM, ifc.MemWriteM, ifc.RegWriteM}, 32'h0);
        chk("t4_bubble", 32'(ifc.BubbleCnt), 32'd1);
        ifc.FlushM = 1'b0; ifc.StallM = 1'b0;

        // 5: invalid E-stage slot must not write
        ifc.ValidE = 1'b0; ifc.RegWriteE = 1'b1; ifc.MemWriteE = 1'b1;
        step("t5_bubble");
        chk("t5_ctl", {29'd0, ifc.ValidM, ifc.MemWriteM, ifc.RegWriteM}, 32'h0);
        chk("t5_bubble", 32'(ifc.BubbleCnt), 32'd2);

        // 6: long stall with a valid instruction saturates the counter
        ifc.ValidE = 1'b1;
        step("t6_load");
        ifc.StallM = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_e();
            step("t6_stall");
        end
        chk("t6_sat", 32'(ifc.StallCnt), 32'd15);
        ifc.StallM = 1'b0;

        // Random traffic, including resets landing mid-stall/flush
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 31) == 0);
            ifc.StallM = ($urandom_range(0, 3) == 0);
            ifc.FlushM = ($urandom_range(0, 7) == 0);
            ifc.ValidE = ($urandom_range(0, 3) != 0);
            rand_e();
            step("rnd");
            chk("rnd_invariant", 32'(!ifc.ValidM && (ifc.RegWriteM || ifc.MemWriteM)), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
